// File: rtl/hdlc_pkg.sv
// Shared HDLC constants, receiver state encoding and the serial CRC-16-CCITT step.
package hdlc_pkg;

  localparam logic [7:0]  FLAG        = 8'h7E;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;
  localparam logic [15:0] CRC_POLY    = 16'h1021;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SYNC  = 2'd1,
    FRAME = 2'd2
  } rx_state_t;

  // Shift-left form, feedback taken from bit 15 xor the incoming line bit.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/hdlc_crc16.sv
// Serial CRC-16-CCITT register: init reloads FFFF, en folds in one bit per cycle.
module hdlc_crc16
  import hdlc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        init,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     crc <= CRC_INIT;
    else if (init) crc <= CRC_INIT;
    else if (en)   crc <= crc16_step(crc, bit_in);
  end

endmodule

// File: rtl/hdlc_rx.sv
// HDLC receiver: flag hunt, destuff, CRC check, 2-byte FCS holdback; data lags the line by 8 bits.
// No backpressure; strobes are registered. Defining RX_ADDR_FILTER_EN adds station_id filtering.
module hdlc_rx
  import hdlc_pkg::*;
#(
  parameter int MIN_LEN = 4,
  parameter int LEN_W   = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rxdata,
  output logic [7:0]       data_out,
  output logic             data_valid,
  output logic             data_first,
  output logic             frame_end,
  output logic             frame_ok,
  output logic [LEN_W-1:0] frame_len,
  output logic             abort,
  output logic             line_idle
`ifdef RX_ADDR_FILTER_EN
  ,
  input  logic [7:0]       station_id
`endif
);

  rx_state_t        state, state_nx;
  logic [7:0]       win, wvld, win_nx;
  logic             flag_raw, flag_d;
  logic [3:0]       ones, ones_nx;
  logic             abort_cond;
  logic [2:0]       dp_ones, bitcnt;
  logic [6:0]       shreg;
  logic [7:0]       byte_nx, pipe0, pipe1;
  logic [LEN_W-1:0] len;
  logic [15:0]      crc;
  logic             dbit, dvld, kept, byte_done;
  logic             pass_byte, pass_frame;
  logic             emit_nx, first_nx, fend_nx, fok_nx, abort_nx;

  assign win_nx     = {rxdata, win[7:1]};
  assign flag_raw   = (win_nx == FLAG);
  assign ones_nx    = !rxdata ? 4'd0 : ((ones == 4'hF) ? ones : ones + 4'd1);
  assign abort_cond = (ones >= 4'd7);

  assign dbit      = win[0];
  assign dvld      = wvld[0];
  assign kept      = dvld && !(dp_ones == 3'd5 && !dbit) && (state != HUNT);
  assign byte_nx   = {dbit, shreg};
  assign byte_done = kept && (bitcnt == 3'd7);

`ifdef RX_ADDR_FILTER_EN
  logic drop, hit;
  // Byte 0 sits at the far end of the pipe exactly when the first emission is due.
  assign hit        = (pipe1 == station_id) || (pipe1 == 8'hFF);
  assign pass_byte  = (len == LEN_W'(2)) ? hit : !drop;
  assign pass_frame = !drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                drop <= 1'b0;
    else if (flag_d)                          drop <= 1'b0;
    else if (byte_done && len == LEN_W'(2))   drop <= !hit;
  end
`else
  assign pass_byte  = 1'b1;
  assign pass_frame = 1'b1;
`endif

  // Raw line window; a flag empties the valid mask so its bits never reach the data path.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win       <= 8'h00;
      wvld      <= 8'h00;
      flag_d    <= 1'b0;
      ones      <= 4'd0;
      line_idle <= 1'b0;
    end else begin
      win       <= win_nx;
      wvld      <= flag_raw ? 8'h00 : {1'b1, wvld[7:1]};
      flag_d    <= flag_raw;
      ones      <= ones_nx;
      line_idle <= (ones_nx == 4'hF);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dp_ones <= 3'd0;
      bitcnt  <= 3'd0;
      shreg   <= 7'd0;
      len     <= '0;
      pipe0   <= 8'h00;
      pipe1   <= 8'h00;
    end else if (flag_d) begin
      dp_ones <= 3'd0;
      bitcnt  <= 3'd0;
      len     <= '0;
      pipe0   <= 8'h00;
      pipe1   <= 8'h00;
    end else begin
      if (dvld) dp_ones <= !dbit ? 3'd0 : ((dp_ones == 3'd5) ? dp_ones : dp_ones + 3'd1);
      if (kept) begin
        shreg  <= byte_nx[7:1];
        bitcnt <= bitcnt + 3'd1;
      end
      if (byte_done) begin
        pipe0 <= byte_nx;
        pipe1 <= pipe0;
        len   <= (len == '1) ? len : len + LEN_W'(1);
      end
    end
  end

  hdlc_crc16 u_crc (
    .clk    (clk),
    .reset  (reset),
    .init   (flag_d),
    .en     (kept),
    .bit_in (dbit),
    .crc    (crc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HUNT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      HUNT:    if (flag_d) state_nx = SYNC;
      SYNC:    if (abort_cond) state_nx = HUNT;
               else if (kept) state_nx = FRAME;
      FRAME:   if (flag_d) state_nx = SYNC;
               else if (abort_cond) state_nx = HUNT;
      default: state_nx = HUNT;
    endcase
  end

  always_comb begin
    emit_nx  = byte_done && (len >= LEN_W'(2)) && pass_byte;
    first_nx = (len == LEN_W'(2));
    fend_nx  = (state == FRAME) && flag_d && pass_frame;
    fok_nx   = (bitcnt == 3'd0) && (len >= LEN_W'(MIN_LEN)) && (crc == CRC_RESIDUE);
    abort_nx = (state == FRAME) && abort_cond && !flag_d && pass_frame;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      data_first <= 1'b0;
      frame_end  <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
      abort      <= 1'b0;
    end else begin
      data_valid <= emit_nx;
      data_first <= emit_nx && first_nx;
      if (emit_nx) data_out <= pipe1;
      frame_end  <= fend_nx;
      if (fend_nx) begin
        frame_ok  <= fok_nx;
        frame_len <= len;
      end
      abort      <= abort_nx;
    end
  end

endmodule

// File: tb/tb_hdlc_rx.sv
// Scoreboard bench for hdlc_rx: a bit-level transmitter model pushes expected bytes/frame ends.
module tb_hdlc_rx;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             rxdata = 1'b1;
  logic [7:0]       data_out;
  logic             data_valid, data_first, frame_end, frame_ok, abort, line_idle;
  logic [LEN_W-1:0] frame_len;
`ifdef RX_ADDR_FILTER_EN
  logic [7:0]       station_id = 8'h05;
`endif

  always #5 clk = ~clk;

  hdlc_rx #(.MIN_LEN(4), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rxdata     (rxdata),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_first (data_first),
    .frame_end  (frame_end),
    .frame_ok   (frame_ok),
    .frame_len  (frame_len),
    .abort      (abort),
    .line_idle  (line_idle)
`ifdef RX_ADDR_FILTER_EN
    ,
    .station_id (station_id)
`endif
  );

  int             checks = 0;
  int             errors = 0;
  int             exp_aborts = 0;
  int             tx_ones = 0;
  logic [8:0]     byte_q[$];
  logic [LEN_W:0] end_q[$];
  logic [8:0]     eb;
  logic [LEN_W:0] ee;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (c[15] ^ b) r = r ^ 16'h1021;
    return r;
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    rxdata = b;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
    tx_ones = 0;
  endtask

  task automatic tx_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic tx_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_data_bit(v[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  // CRC is always taken over the intended bytes; flip corrupts the wire copy only.
  task automatic send_frame(input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3,
                            input int flip, input logic [7:0] mask, input bit open);
    logic [7:0]  d[4];
    logic [7:0]  t;
    logic [15:0] c, fcs;
    bit          pass, ok;
    d[0] = b0; d[1] = b1; d[2] = b2; d[3] = b3;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) c = crc_upd(c, d[i][j]);
    fcs  = ~c;
    ok   = (flip < 0) && (n + 2 >= 4);
    pass = 1'b1;
`ifdef RX_ADDR_FILTER_EN
    pass = (n == 0) || (d[0] == station_id) || (d[0] == 8'hFF);
`endif
    if (pass) begin
      for (int i = 0; i < n; i++) begin
        t = (i == flip) ? (d[i] ^ mask) : d[i];
        byte_q.push_back({i == 0, t});
      end
      end_q.push_back({ok, LEN_W'(n + 2)});
    end
    if (open) send_flag();
    for (int i = 0; i < n; i++) tx_byte((i == flip) ? (d[i] ^ mask) : d[i]);
    for (int k = 15; k >= 0; k--) tx_data_bit(fcs[k]);
    send_flag();
  endtask

  task automatic drain(input string tag);
    idle(30);
    check({tag, "_bytes_left"}, byte_q.size(), 0);
    check({tag, "_ends_left"}, end_q.size(), 0);
    check({tag, "_aborts_left"}, exp_aborts, 0);
  endtask

  always begin
    @(posedge clk);
    #1;
    if (data_valid) begin
      check("byte_expected", byte_q.size() != 0, 1);
      if (byte_q.size() != 0) begin
        eb = byte_q.pop_front();
        check("data_out", data_out, eb[7:0]);
        check("data_first", data_first, eb[8]);
      end
    end
    if (frame_end) begin
      check("end_expected", end_q.size() != 0, 1);
      if (end_q.size() != 0) begin
        ee = end_q.pop_front();
        check("frame_ok", frame_ok, ee[LEN_W]);
        check("frame_len", frame_len, ee[LEN_W-1:0]);
      end
    end
    if (abort) begin
      check("abort_expected", exp_aborts > 0, 1);
      if (exp_aborts > 0) exp_aborts--;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_valid", data_valid, 0);
    check("rst_frame_end", frame_end, 0);
    check("rst_frame_ok", frame_ok, 0);
    check("rst_frame_len", frame_len, 0);
    check("rst_data_out", data_out, 0);
    check("rst_abort", abort, 0);
    check("rst_line_idle", line_idle, 0);
    @(negedge clk);
    reset = 1'b0;
    idle(4);

    send_frame(4, 8'h01, 8'h00, 8'hFE, 8'h00, -1, 8'h00, 1'b1);
    drain("basic");
    send_frame(3, 8'hFF, 8'h7E, 8'h3F, 8'h00, -1, 8'h00, 1'b1);
    drain("stuffed");
    send_frame(3, 8'hFF, 8'h7E, 8'h3F, 8'h00, 1, 8'h01, 1'b1);
    drain("bad_crc");
    send_frame(1, 8'h5A, 8'h00, 8'h00, 8'h00, -1, 8'h00, 1'b1);
    drain("short");
    send_frame(2, 8'h11, 8'h22, 8'h00, 8'h00, -1, 8'h00, 1'b1);
    send_frame(2, 8'h33, 8'h44, 8'h00, 8'h00, -1, 8'h00, 1'b0);
    drain("shared_flag");

    // 12 data bits then a closing flag: one whole byte counted, bit counter not aligned.
    end_q.push_back({1'b0, LEN_W'(1)});
    send_flag();
    for (int i = 0; i < 12; i++) tx_data_bit(((12'hABC >> i) & 12'h1) != 0);
    send_flag();
    drain("misaligned");

    send_flag();
    tx_byte(8'h12);
    tx_byte(8'h34);
    exp_aborts = 1;
    idle(7);
    @(posedge clk);
    #2;
    check("idle_after_7", line_idle, 0);
    idle(13);
    @(posedge clk);
    #2;
    check("idle_after_20", line_idle, 1);
    send_frame(2, 8'hA5, 8'h5A, 8'h00, 8'h00, -1, 8'h00, 1'b1);
    @(posedge clk);
    #2;
    check("idle_cleared", line_idle, 0);
    drain("abort_idle");

    send_flag();
    tx_byte(8'hC3);
    tx_byte(8'h3C);
    tx_byte(8'h99);
    for (int i = 0; i < 4; i++) tx_data_bit(1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_frame_len", frame_len, 0);
    check("midrst_data_out", data_out, 0);
    reset = 1'b0;
    drain("mid_reset");

`ifdef RX_ADDR_FILTER_EN
    send_frame(3, 8'h05, 8'hA1, 8'hA2, 8'h00, -1, 8'h00, 1'b1);
    drain("flt_own");
    send_frame(3, 8'hFF, 8'hB1, 8'hB2, 8'h00, -1, 8'h00, 1'b1);
    drain("flt_bcast");
    send_frame(3, 8'h07, 8'hC1, 8'hC2, 8'h00, -1, 8'h00, 1'b1);
    drain("flt_other");
    send_frame(2, 8'h05, 8'hD1, 8'h00, 8'h00, -1, 8'h00, 1'b1);
    drain("flt_recover");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
